test_ram_master: RTL and testbench

Bus-master sequencer that drives the byte-wide synchronous `test_ram` from the initiator side. It accepts 1–3 byte read or write requests from the 65c816 core (operand fetch, push/pull, data access). It breaks each request into consecutive byte accesses on the RAM port. It returns read data assembled little-endian. It sits between the core's memory request port and `test_ram`, and it is the block the test bench instantiates to exercise the RAM.

---
 rtl/test_ram_master_pkg.sv | 43 ++++
 rtl/test_ram_master.sv | 151 +++++++++++++++
 tb/tb_test_ram_master.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/test_ram_master_pkg.sv
// Shared widths, FSM encodings and helpers for the test_ram bus master.
package test_ram_master_pkg;

  localparam int tr_addr_msb_pos = 15;
  localparam int tr_data_msb_pos = 7;
  localparam int tr_max_len      = 3;
  localparam int tr_bus_width    = tr_max_len * 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  // A zero length request is served as a single byte.
  function automatic logic [1:0] eff_len(input logic [1:0] len);
    return (len == 2'd0) ? 2'd1 : len;
  endfunction

  function automatic logic [7:0] get_byte(input logic [tr_bus_width-1:0] v, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = v[7:0];
      2'd1:    b = v[15:8];
      2'd2:    b = v[23:16];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  function automatic logic [tr_bus_width-1:0] put_byte(input logic [tr_bus_width-1:0] v,
                                                       input logic [1:0] idx,
                                                       input logic [7:0] b);
    logic [tr_bus_width-1:0] r;
    r = v;
    case (idx)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r = v;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/test_ram_master.sv
// Splits 1-3 byte core requests into byte accesses on the synchronous test_ram
// port and assembles read data little-endian.
module test_ram_master
  import test_ram_master_pkg::*;
#(
  parameter int ADDR_WIDTH = tr_addr_msb_pos + 1,
  parameter int DATA_WIDTH = tr_data_msb_pos + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_we,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic [1:0]              req_len,
  input  logic [tr_bus_width-1:0] req_wdata,
  output logic                    rsp_valid,
  output logic [tr_bus_width-1:0] rsp_rdata,
  output logic                    ram_we,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_wdata,
  input  logic [DATA_WIDTH-1:0]   ram_rdata
);

  logic [1:0]              state_q,     state_d;
  logic [2:0]              cnt_q,       cnt_d;
  logic [1:0]              len_q,       len_d;
  logic [tr_bus_width-1:0] wbuf_q,      wbuf_d;
  logic [tr_bus_width-1:0] acc_q,       acc_d;
  logic [tr_bus_width-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic                    req_ready_q, req_ready_d;
  logic                    ram_we_q,    ram_we_d;
  logic [ADDR_WIDTH-1:0]   ram_addr_q,  ram_addr_d;
  logic [DATA_WIDTH-1:0]   ram_wdata_q, ram_wdata_d;

  // cnt_q is the number of edges since the handshake; reads issue while
  // cnt_q < N and capture byte cnt_q-2 because the RAM read is registered.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    wbuf_d      = wbuf_q;
    acc_d       = acc_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_valid_d = 1'b0;
    req_ready_d = req_ready_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    case (state_q)
      ST_IDLE: begin
        req_ready_d = 1'b1;
        if (req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          len_d       = eff_len(req_len);
          wbuf_d      = req_wdata;
          ram_addr_d  = req_addr;
          cnt_d       = 3'd1;
          if (req_we) begin
            state_d     = ST_WRITE;
            ram_we_d    = 1'b1;
            ram_wdata_d = req_wdata[7:0];
          end else begin
            state_d  = ST_READ;
            ram_we_d = 1'b0;
            acc_d    = '0;
          end
        end else begin
          ram_we_d = 1'b0;
        end
      end
      ST_READ: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q < {1'b0, len_q}) begin
          ram_addr_d = ram_addr_q + ADDR_WIDTH'(1);
        end else begin
          ram_addr_d = ram_addr_q;
        end
        if (cnt_q >= 3'd2) begin
          acc_d = put_byte(acc_q, 2'(cnt_q - 3'd2), ram_rdata);
        end else begin
          acc_d = acc_q;
        end
        if (cnt_q == ({1'b0, len_q} + 3'd1)) begin
          state_d     = ST_IDLE;
          req_ready_d = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = acc_d;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_WRITE: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q < {1'b0, len_q}) begin
          ram_addr_d  = ram_addr_q + ADDR_WIDTH'(1);
          ram_wdata_d = get_byte(wbuf_q, cnt_q[1:0]);
          ram_we_d    = 1'b1;
        end else begin
          ram_we_d    = 1'b0;
          state_d     = ST_IDLE;
          req_ready_d = 1'b1;
          rsp_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b0;
        ram_we_d    = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      len_q       <= 2'd0;
      wbuf_q      <= '0;
      acc_q       <= '0;
      rsp_rdata_q <= '0;
      rsp_valid_q <= 1'b0;
      req_ready_q <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      wbuf_q      <= wbuf_d;
      acc_q       <= acc_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_valid_q <= rsp_valid_d;
      req_ready_q <= req_ready_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_test_ram_master.sv
// Self-checking bench: behavioural byte RAM, array reference model, directed
// table plus random requests and a mid-transfer reset.
module tb_test_ram_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [1:0]  req_len;
  logic [23:0] req_wdata;
  logic        rsp_valid;
  logic [23:0] rsp_rdata;
  logic        ram_we;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;

  logic [7:0]  mem   [0:65535];
  logic [7:0]  model [0:65535];
  logic [23:0] last_rd;
  int checks = 0;
  int errors = 0;
  int rsp_seen = 0;
  int rsp_expected = 0;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [1:0]  len;
    logic [23:0] wdata;
    logic [23:0] exp;
  } vec_t;
  vec_t vecs[9];

  test_ram_master #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Byte RAM with registered read, as test_ram behaves.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  always @(negedge clk) if (rsp_valid) rsp_seen++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_req(input logic we, input logic [15:0] addr, input logic [1:0] len,
                        input logic [23:0] wdata, output logic [23:0] got);
    int n, lat, b;
    bit done;
    logic [23:0] exp;
    n = (len == 2'd0) ? 1 : int'(len);
    got = 24'h0;
    b = 0;
    while (!req_ready && b < 20) begin @(negedge clk); b++; end
    if (!req_ready) begin chk("ready_timeout", 32'd0, 32'd1); return; end
    req_valid = 1'b1; req_we = we; req_addr = addr; req_len = len; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_addr = 16'($urandom);
    req_len = 2'($urandom); req_wdata = 24'($urandom);
    lat = 0; done = 0;
    while (!done) begin
      if (lat < n) begin
        chk("ram_addr", 32'(ram_addr), 32'(16'(addr + 16'(lat))));
        chk("ram_we", 32'(ram_we), 32'(we));
        if (we) chk("ram_wdata", 32'(ram_wdata), 32'((wdata >> (8 * lat)) & 24'hFF));
      end
      if (rsp_valid || lat >= 8) done = 1;
      else begin @(posedge clk); #1; lat++; end
    end
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("latency", 32'(lat), we ? 32'(n) : 32'(n + 1));
    chk("ready_at_done", 32'(req_ready), 32'd1);
    got = rsp_rdata;
    if (rsp_valid) rsp_expected++;
    if (we) begin
      for (int i = 0; i < n; i++) begin
        model[16'(addr + 16'(i))] = 8'((wdata >> (8 * i)) & 24'hFF);
        chk("ram_content", 32'(mem[16'(addr + 16'(i))]), 32'(model[16'(addr + 16'(i))]));
      end
      chk("we_low_at_done", 32'(ram_we), 32'd0);
      chk("rdata_held", 32'(rsp_rdata), 32'(last_rd));
    end else begin
      exp = 24'h0;
      for (int i = 0; i < n; i++) exp = exp | (24'(model[16'(addr + 16'(i))]) << (8 * i));
      chk("rsp_rdata", 32'(rsp_rdata), 32'(exp));
      last_rd = exp;
    end
  endtask

  initial begin
    logic [23:0] got;
    logic [15:0] a;
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'($urandom);
      model[i] = mem[i];
    end
    mem[16'h10] = 8'hA9; mem[16'h11] = 8'h34; mem[16'h12] = 8'h12;
    mem[16'h31] = 8'hC3; mem[16'h32] = 8'h5A;
    for (int i = 16'h40; i < 16'h43; i++) mem[i] = 8'hAA;
    for (int i = 0; i < 65536; i++) model[i] = mem[i];
    last_rd = 24'h0;

    rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 16'h0;
    req_len = 2'd0; req_wdata = 24'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", 32'(rsp_rdata), 32'd0);
    chk("rst_we", 32'(ram_we), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_wdata", 32'(ram_wdata), 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_rst", 32'(req_ready), 32'd1);

    vecs[0] = '{1'b0, 16'h0010, 2'd3, 24'h0,      24'h1234A9};
    vecs[1] = '{1'b1, 16'h0020, 2'd2, 24'h00BEEF, 24'h1234A9};
    vecs[2] = '{1'b0, 16'h0020, 2'd2, 24'h0,      24'h00BEEF};
    vecs[3] = '{1'b1, 16'hFFFF, 2'd3, 24'h563412, 24'h00BEEF};
    vecs[4] = '{1'b0, 16'h0000, 2'd1, 24'h0,      24'h000034};
    vecs[5] = '{1'b0, 16'hFFFF, 2'd3, 24'h0,      24'h563412};
    vecs[6] = '{1'b0, 16'h0010, 2'd0, 24'h0,      24'h0000A9};
    vecs[7] = '{1'b1, 16'h0030, 2'd0, 24'hFFFF77, 24'h0000A9};
    vecs[8] = '{1'b0, 16'h0030, 2'd3, 24'h0,      24'h5AC377};
    for (int v = 0; v < 9; v++) begin
      do_req(vecs[v].we, vecs[v].addr, vecs[v].len, vecs[v].wdata, got);
      chk("table_rdata", 32'(got), 32'(vecs[v].exp));
    end
    chk("len0_single_write", 32'(mem[16'h31]), 32'h0000_00C3);

    for (int r = 0; r < 40; r++) begin
      a = 16'($urandom);
      if ($urandom_range(0, 3) == 0) a = 16'hFFFE + 16'($urandom_range(0, 2));
      do_req(1'($urandom), a, 2'($urandom), 24'($urandom), got);
    end

    // Reset one edge into a 3-byte write: only byte 0 reaches the RAM.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0040; req_len = 2'd3;
    req_wdata = 24'h332211;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_we", 32'(ram_we), 32'd0);
    chk("abort_rsp", 32'(rsp_valid), 32'd0);
    chk("abort_ready", 32'(req_ready), 32'd0);
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("abort_byte0", 32'(mem[16'h40]), 32'h11);
    chk("abort_byte1", 32'(mem[16'h41]), 32'hAA);
    chk("abort_byte2", 32'(mem[16'h42]), 32'hAA);
    model[16'h40] = 8'h11;
    do_req(1'b0, 16'h0040, 2'd3, 24'h0, got);
    chk("post_abort_read", 32'(got), 32'h00AAAA11);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rsp_pulse_count", 32'(rsp_seen), 32'(rsp_expected));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
